parity_fifo_v2: RTL and testbench



---
 rtl/parity_fifo_v2.sv | 127 ++++++++++++
 tb/tb_parity_fifo_v2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_fifo_v2.sv
// Parity-protected synchronous FIFO with first-word fall-through, arbitrary depth,
// selectable parity polarity and corrupt-head handling (none / drop / flag).
module parity_fifo_v2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int EVEN_ODD      = 0,
  parameter int PARITY_MODE   = 1,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_i,
  input  logic [DATA_WIDTH:0]              push_data_i,
  input  logic                             push_valid_i,
  output logic                             push_grant_o,
  input  logic                             pop_grant_i,
  output logic [DATA_WIDTH:0]              pop_data_o,
  output logic                             pop_valid_o,
  output logic                             pop_err_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
  output logic                             almost_full_o,
  output logic                             almost_empty_o,
  output logic                             overflow_o,
  output logic                             underflow_o,
  output logic [ERR_CNT_WIDTH-1:0]         err_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_DROP = 2'd1,
    MODE_FLAG = 2'd2
  } mode_e;

  localparam logic [1:0] MODE_BITS = PARITY_MODE[1:0];
  localparam mode_e      MODE      = mode_e'(MODE_BITS);
  localparam logic       POL       = EVEN_ODD[0];

  logic [DATA_WIDTH:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic                   r_ovf;
  logic                   r_unf;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic [DATA_WIDTH:0]    w_head;
  logic                   w_nonempty;
  logic                   w_head_bad;
  logic                   w_pop_valid;
  logic                   w_discard;
  logic                   w_pop;
  logic                   w_push_grant;
  logic                   w_push;

  // Wrap by compare so non-power-of-two depths index only valid entries.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_head       = r_mem[r_rptr];
    w_nonempty   = (r_count != '0);
    w_head_bad   = w_nonempty && (MODE != MODE_NONE) && ((^w_head) != POL);
    w_pop_valid  = w_nonempty && !((MODE == MODE_DROP) && w_head_bad);
    w_discard    = (MODE == MODE_DROP) && w_head_bad && pop_grant_i;
    w_pop        = (w_pop_valid && pop_grant_i) || w_discard;
    w_push_grant = !rst && (r_count < DEPTH_C);
    w_push       = push_valid_i && w_push_grant;
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear_i) begin
      r_mem[r_wptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_err_cnt <= '0;
    end else if (clear_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_ovf <= push_valid_i && !w_push_grant;
      r_unf <= pop_grant_i && !w_nonempty && !w_push;
      if (w_pop && w_head_bad && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  assign push_grant_o   = w_push_grant;
  assign pop_valid_o    = w_pop_valid;
  assign pop_data_o     = w_pop_valid ? w_head : '0;
  assign pop_err_o      = (MODE == MODE_FLAG) && w_head_bad;
  assign count_o        = r_count;
  assign almost_full_o  = (r_count >= AF_C);
  assign almost_empty_o = (r_count <= AE_C);
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_unf;
  assign err_count_o    = r_err_cnt;

endmodule

// File: tb/tb_parity_fifo_v2.sv
// Directed bench for parity_fifo_v2: four instances (drop/flag/none at depth 4,
// drop at depth 5) share one stimulus stream; expectations are hand-computed.
module tb_parity_fifo_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [8:0] pdin;
  logic       pvalid;
  logic       pgrant;

  logic       grant  [4];
  logic [8:0] pdata  [4];
  logic       pvld   [4];
  logic       perr   [4];
  logic [2:0] cnt    [4];
  logic       af     [4];
  logic       ae     [4];
  logic       ovf    [4];
  logic       unf    [4];
  logic [7:0] errc   [4];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // 0: depth4 drop, 1: depth4 flag, 2: depth4 no-check, 3: depth5 drop
  for (genvar g = 0; g < 4; g++) begin : g_dut
    parity_fifo_v2 #(
      .DATA_WIDTH   (8),
      .FIFO_DEPTH   ((g == 3) ? 5 : 4),
      .EVEN_ODD     (0),
      .PARITY_MODE  ((g == 1) ? 2 : ((g == 2) ? 0 : 1)),
      .ERR_CNT_WIDTH(8)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (clear),
      .push_data_i   (pdin),
      .push_valid_i  (pvalid),
      .push_grant_o  (grant[g]),
      .pop_grant_i   (pgrant),
      .pop_data_o    (pdata[g]),
      .pop_valid_o   (pvld[g]),
      .pop_err_o     (perr[g]),
      .count_o       (cnt[g]),
      .almost_full_o (af[g]),
      .almost_empty_o(ae[g]),
      .overflow_o    (ovf[g]),
      .underflow_o   (unf[g]),
      .err_count_o   (errc[g])
    );
  end

  typedef struct {
    logic       pv;
    logic [8:0] pd;
    logic       pg;
    logic [2:0] e_cnt;
    logic       e_grant;
    logic       e_af;
    logic       e_ae;
    logic       e_ovf;
    logic       e_unf;
    logic       e_vld;
    logic [8:0] e_data;
    logic [7:0] e_errc;
    logic       b_vld;
    logic [8:0] b_data;
    logic       b_err;
    logic [7:0] b_errc;
  } vec_t;

  vec_t vt [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input logic pv, input logic [8:0] pd, input logic pg, input logic cl);
    pvalid = pv;
    pdin   = pd;
    pgrant = pg;
    clear  = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pvalid = 1'b0; pdin = '0; pgrant = 1'b0; clear = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [8:0] w9(input int k);
    logic [7:0] d;
    d = 8'(k * 37 + 3);
    return {^d, d};
  endfunction

  initial begin
    //        pv  pd      pg  cnt  gr af ae ov un vld data    ec    bvld bdata  berr bec
    vt[0]  = '{1, 9'h003, 0, 3'd1, 1, 0, 1, 0, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[1]  = '{1, 9'h005, 0, 3'd2, 1, 0, 0, 0, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[2]  = '{1, 9'h006, 0, 3'd3, 1, 1, 0, 0, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[3]  = '{1, 9'h009, 0, 3'd4, 0, 1, 0, 0, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[4]  = '{1, 9'h00A, 0, 3'd4, 0, 1, 0, 1, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[5]  = '{1, 9'h00C, 0, 3'd4, 0, 1, 0, 1, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[6]  = '{0, 9'h000, 1, 3'd3, 1, 1, 0, 0, 0, 1, 9'h005, 8'd0, 1, 9'h005, 0, 8'd0};
    vt[7]  = '{0, 9'h000, 1, 3'd2, 1, 0, 0, 0, 0, 1, 9'h006, 8'd0, 1, 9'h006, 0, 8'd0};
    vt[8]  = '{0, 9'h000, 1, 3'd1, 1, 0, 1, 0, 0, 1, 9'h009, 8'd0, 1, 9'h009, 0, 8'd0};
    vt[9]  = '{0, 9'h000, 1, 3'd0, 1, 0, 1, 0, 0, 0, 9'h000, 8'd0, 0, 9'h000, 0, 8'd0};
    vt[10] = '{0, 9'h000, 1, 3'd0, 1, 0, 1, 0, 1, 0, 9'h000, 8'd0, 0, 9'h000, 0, 8'd0};
    vt[11] = '{0, 9'h000, 1, 3'd0, 1, 0, 1, 0, 1, 0, 9'h000, 8'd0, 0, 9'h000, 0, 8'd0};
    vt[12] = '{0, 9'h000, 0, 3'd0, 1, 0, 1, 0, 0, 0, 9'h000, 8'd0, 0, 9'h000, 0, 8'd0};
    vt[13] = '{1, 9'h003, 0, 3'd1, 1, 0, 1, 0, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[14] = '{1, 9'h103, 0, 3'd2, 1, 0, 0, 0, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[15] = '{1, 9'h005, 0, 3'd3, 1, 1, 0, 0, 0, 1, 9'h003, 8'd0, 1, 9'h003, 0, 8'd0};
    vt[16] = '{0, 9'h000, 1, 3'd2, 1, 0, 0, 0, 0, 0, 9'h000, 8'd0, 1, 9'h103, 1, 8'd0};
    vt[17] = '{0, 9'h000, 1, 3'd1, 1, 0, 1, 0, 0, 1, 9'h005, 8'd1, 1, 9'h005, 0, 8'd1};
    vt[18] = '{0, 9'h000, 1, 3'd0, 1, 0, 1, 0, 0, 0, 9'h000, 8'd1, 0, 9'h000, 0, 8'd1};
    vt[19] = '{0, 9'h000, 0, 3'd0, 1, 0, 1, 0, 0, 0, 9'h000, 8'd1, 0, 9'h000, 0, 8'd1};

    // Reset values while rst is held
    pvalid = 1'b0; pdin = '0; pgrant = 1'b0; clear = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_grant", 32'(grant[0]), 0);
    chk("rst_pvld",  32'(pvld[0]), 0);
    chk("rst_pdata", 32'(pdata[0]), 0);
    chk("rst_perr",  32'(perr[1]), 0);
    chk("rst_ae",    32'(ae[0]), 1);
    chk("rst_af",    32'(af[0]), 0);
    chk("rst_ovf",   32'(ovf[0]), 0);
    chk("rst_unf",   32'(unf[0]), 0);
    chk("rst_errc",  32'(errc[0]), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_grant", 32'(grant[0]), 1);

    // Fill/overflow, drain/underflow, corrupt-entry stream across three modes
    for (int i = 0; i < 20; i++) begin
      cyc(vt[i].pv, vt[i].pd, vt[i].pg, 1'b0);
      chk($sformatf("v%0d_cnt", i),   32'(cnt[0]),   32'(vt[i].e_cnt));
      chk($sformatf("v%0d_grant", i), 32'(grant[0]), 32'(vt[i].e_grant));
      chk($sformatf("v%0d_af", i),    32'(af[0]),    32'(vt[i].e_af));
      chk($sformatf("v%0d_ae", i),    32'(ae[0]),    32'(vt[i].e_ae));
      chk($sformatf("v%0d_ovf", i),   32'(ovf[0]),   32'(vt[i].e_ovf));
      chk($sformatf("v%0d_unf", i),   32'(unf[0]),   32'(vt[i].e_unf));
      chk($sformatf("v%0d_vld", i),   32'(pvld[0]),  32'(vt[i].e_vld));
      chk($sformatf("v%0d_data", i),  32'(pdata[0]), 32'(vt[i].e_data));
      chk($sformatf("v%0d_perr", i),  32'(perr[0]),  0);
      chk($sformatf("v%0d_errc", i),  32'(errc[0]),  32'(vt[i].e_errc));
      chk($sformatf("v%0d_m2_cnt", i),  32'(cnt[1]),   32'(vt[i].e_cnt));
      chk($sformatf("v%0d_m2_vld", i),  32'(pvld[1]),  32'(vt[i].b_vld));
      chk($sformatf("v%0d_m2_data", i), 32'(pdata[1]), 32'(vt[i].b_data));
      chk($sformatf("v%0d_m2_perr", i), 32'(perr[1]),  32'(vt[i].b_err));
      chk($sformatf("v%0d_m2_errc", i), 32'(errc[1]),  32'(vt[i].b_errc));
      chk($sformatf("v%0d_m0_vld", i),  32'(pvld[2]),  32'(vt[i].b_vld));
      chk($sformatf("v%0d_m0_data", i), 32'(pdata[2]), 32'(vt[i].b_data));
      chk($sformatf("v%0d_m0_perr", i), 32'(perr[2]),  0);
      chk($sformatf("v%0d_m0_errc", i), 32'(errc[2]),  0);
    end

    // Depth-5 instance: steady simultaneous push/pop across pointer wrap
    do_reset();
    cyc(1'b1, w9(0), 1'b0, 1'b0);
    cyc(1'b1, w9(1), 1'b0, 1'b0);
    chk("d5_prefill_cnt",  32'(cnt[3]), 2);
    chk("d5_prefill_head", 32'(pdata[3]), 32'(w9(0)));
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, w9(i + 2), 1'b1, 1'b0);
      chk($sformatf("d5_stream%0d_cnt", i),  32'(cnt[3]), 2);
      chk($sformatf("d5_stream%0d_head", i), 32'(pdata[3]), 32'(w9(i + 1)));
    end
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("d5_drain1_head", 32'(pdata[3]), 32'(w9(13)));
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("d5_drain2_cnt", 32'(cnt[3]), 0);
    cyc(1'b1, w9(20), 1'b1, 1'b0);
    chk("d5_emptypush_cnt",  32'(cnt[3]), 1);
    chk("d5_emptypush_unf",  32'(unf[3]), 0);
    chk("d5_emptypush_vld",  32'(pvld[3]), 1);
    chk("d5_emptypush_data", 32'(pdata[3]), 32'(w9(20)));
    cyc(1'b0, 9'h000, 1'b0, 1'b0);
    chk("d5_emptypush_unf_after", 32'(unf[3]), 0);
    chk("d5_emptypush_cnt_after", 32'(cnt[3]), 1);

    // Clear with push in flight, then reset mid-stream
    do_reset();
    cyc(1'b1, 9'h103, 1'b0, 1'b0);
    cyc(1'b1, 9'h103, 1'b1, 1'b0);
    chk("cl_pushdiscard_cnt",  32'(cnt[0]), 1);
    chk("cl_pushdiscard_errc", 32'(errc[0]), 1);
    cyc(1'b0, 9'h000, 1'b1, 1'b0);
    chk("cl_discard_cnt",  32'(cnt[0]), 0);
    chk("cl_discard_errc", 32'(errc[0]), 2);
    cyc(1'b1, 9'h003, 1'b0, 1'b0);
    cyc(1'b1, 9'h005, 1'b0, 1'b0);
    cyc(1'b1, 9'h006, 1'b0, 1'b0);
    chk("cl_pre_cnt", 32'(cnt[0]), 3);
    cyc(1'b1, 9'h009, 1'b1, 1'b1);
    chk("cl_cnt",  32'(cnt[0]), 0);
    chk("cl_vld",  32'(pvld[0]), 0);
    chk("cl_errc", 32'(errc[0]), 2);
    chk("cl_ovf",  32'(ovf[0]), 0);
    chk("cl_unf",  32'(unf[0]), 0);
    cyc(1'b0, 9'h000, 1'b0, 1'b0);
    chk("cl_after_cnt", 32'(cnt[0]), 0);
    chk("cl_after_vld", 32'(pvld[0]), 0);
    cyc(1'b1, 9'h003, 1'b0, 1'b0);
    cyc(1'b1, 9'h005, 1'b0, 1'b0);
    chk("mid_pre_cnt", 32'(cnt[0]), 2);
    pvalid = 1'b1; pdin = 9'h006; pgrant = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cnt",   32'(cnt[0]), 0);
    chk("mid_rst_vld",   32'(pvld[0]), 0);
    chk("mid_rst_data",  32'(pdata[0]), 0);
    chk("mid_rst_grant", 32'(grant[0]), 0);
    chk("mid_rst_errc",  32'(errc[0]), 0);
    chk("mid_rst_af",    32'(af[0]), 0);
    chk("mid_rst_ae",    32'(ae[0]), 1);
    chk("mid_rst_ovf",   32'(ovf[0]), 0);
    chk("mid_rst_unf",   32'(unf[0]), 0);
    chk("mid_rst_m2_perr", 32'(perr[1]), 0);
    rst = 1'b0;
    cyc(1'b0, 9'h000, 1'b0, 1'b0);
    chk("mid_release_grant", 32'(grant[0]), 1);
    chk("mid_release_cnt",   32'(cnt[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
